// File: rtl/param_alu_slave_pkg.sv
// Shared types and constants for the SPI-slave ALU: opcodes, flag bit positions
// and the slave frame state encoding.
package AluPkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int FLAG_COUNT   = 5;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ILL = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10
    } AluOp;

    typedef enum logic [2:0] {
        ST_RECEIVE,
        ST_RECEIVING,
        ST_OPERATE,
        ST_SEND,
        ST_SENDING
    } slave_state_e;

endpackage

// File: rtl/param_alu_slave_spi_if.sv
// SPI bus bundle. miso is a tri-state line: the slave supplies the value and
// its enable, and the wire resolves to Z whenever the slave is not selected.
interface Spi #(
    parameter int NssWidth = 1
);
    logic [NssWidth-1:0] nss;
    logic                mosi;
    logic                miso_d;
    logic                miso_oe;
    wire                 miso;

    assign miso = miso_oe ? miso_d : 1'bz;

    modport SlaveSpi (
        input  nss,
        input  mosi,
        output miso_d,
        output miso_oe
    );

    modport MasterSpi (
        output nss,
        output mosi,
        input  miso
    );
endinterface

// File: rtl/param_alu_slave_alu_core.sv
// Combinational ALU: 11 operations plus {ILL, V, C, N, Z} status flags.
module alu_core
    import AluPkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic [OPCODE_WIDTH-1:0] op_code_i,
    input  logic [DataWidth-1:0]    op_1_i,
    input  logic [DataWidth-1:0]    op_2_i,
    output logic [DataWidth-1:0]    result_o,
    output logic [FLAG_COUNT-1:0]   flags_o
);
    localparam int ShiftWidth = $clog2(DataWidth);
    localparam int Msb        = DataWidth - 1;

    logic [DataWidth:0]    sum;
    logic [DataWidth:0]    diff;
    logic [ShiftWidth-1:0] shamt;
    logic [DataWidth-1:0]  result;
    logic                  carry;
    logic                  overflow;
    logic                  illegal;

    // The extra MSB of diff is the unsigned borrow.
    assign sum   = {1'b0, op_1_i} + {1'b0, op_2_i};
    assign diff  = {1'b0, op_1_i} - {1'b0, op_2_i};
    assign shamt = op_2_i[ShiftWidth-1:0];

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (AluOp'(op_code_i))
            OP_ADD: begin
                result   = sum[DataWidth-1:0];
                carry    = sum[DataWidth];
                overflow = (op_1_i[Msb] == op_2_i[Msb]) && (sum[Msb] != op_1_i[Msb]);
            end
            OP_SUB: begin
                result   = diff[DataWidth-1:0];
                carry    = diff[DataWidth];
                overflow = (op_1_i[Msb] != op_2_i[Msb]) && (diff[Msb] != op_1_i[Msb]);
            end
            OP_AND:  result = op_1_i & op_2_i;
            OP_OR:   result = op_1_i | op_2_i;
            OP_XOR:  result = op_1_i ^ op_2_i;
            OP_NOT:  result = ~op_1_i;
            OP_SHL:  result = op_1_i << shamt;
            OP_SHR:  result = op_1_i >> shamt;
            OP_SRA:  result = $signed(op_1_i) >>> shamt;
            OP_SLT:  result = {{(DataWidth-1){1'b0}}, ($signed(op_1_i) < $signed(op_2_i))};
            OP_SLTU: result = {{(DataWidth-1){1'b0}}, (op_1_i < op_2_i)};
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        flags_o           = '0;
        flags_o[FLAG_Z]   = (result == '0);
        flags_o[FLAG_N]   = result[Msb];
        flags_o[FLAG_C]   = carry;
        flags_o[FLAG_V]   = overflow;
        flags_o[FLAG_ILL] = illegal;
    end

    assign result_o = result;

endmodule

// File: rtl/param_alu_slave.sv
// SPI-slave ALU: shifts in {op_2, op_1, op_code} LSB-first, computes, and shifts
// {flags, result} back out LSB-first; deselection mid-frame aborts the frame.
module param_alu_slave
    import AluPkg::*;
#(
    parameter int DataWidth   = 8,
    parameter int NssPosition = 0
) (
    input  logic   i_clock,
    input  logic   i_reset,
    Spi.SlaveSpi   spi,
    output logic   o_busy,
    output logic   o_frame_err
);
    localparam int InBits  = 2 * DataWidth + OPCODE_WIDTH;
    localparam int OutBits = DataWidth + FLAG_COUNT;
    localparam int CntW    = $clog2(InBits);

    localparam logic [CntW-1:0] LastIn  = CntW'(InBits - 1);
    localparam logic [CntW-1:0] LastOut = CntW'(OutBits - 1);

    slave_state_e         state_q, state_d;
    logic [CntW-1:0]      cnt_in_q, cnt_in_d;
    logic [CntW-1:0]      cnt_out_q, cnt_out_d;
    logic [InBits-1:0]    packet_in_q, packet_in_d;
    logic [OutBits-1:0]   packet_out_q, packet_out_d;
    logic                 frame_err_q, frame_err_d;

    logic                  active;
    logic [DataWidth-1:0]  core_result;
    logic [FLAG_COUNT-1:0] core_flags;

    assign active = !spi.nss[NssPosition];

    alu_core #(.DataWidth(DataWidth)) u_alu_core (
        .op_code_i (packet_in_q[OPCODE_WIDTH-1:0]),
        .op_1_i    (packet_in_q[OPCODE_WIDTH +: DataWidth]),
        .op_2_i    (packet_in_q[OPCODE_WIDTH+DataWidth +: DataWidth]),
        .result_o  (core_result),
        .flags_o   (core_flags)
    );

    // Both packets are shift registers: request bits enter at the MSB so the
    // first bit received ends in bit 0, and response bits leave from bit 0.
    always_comb begin
        state_d      = state_q;
        cnt_in_d     = cnt_in_q;
        cnt_out_d    = cnt_out_q;
        packet_in_d  = packet_in_q;
        packet_out_d = packet_out_q;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_RECEIVE: begin
                if (active && spi.mosi) state_d = ST_RECEIVING;
            end
            ST_RECEIVING: begin
                if (!active) begin
                    state_d     = ST_RECEIVE;
                    cnt_in_d    = '0;
                    cnt_out_d   = '0;
                    packet_in_d = '0;
                    frame_err_d = 1'b1;
                end else begin
                    packet_in_d = {spi.mosi, packet_in_q[InBits-1:1]};
                    if (cnt_in_q == LastIn) begin
                        state_d  = ST_OPERATE;
                        cnt_in_d = '0;
                    end else begin
                        cnt_in_d = cnt_in_q + 1'b1;
                    end
                end
            end
            ST_OPERATE: begin
                packet_out_d = {core_flags, core_result};
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                if (active && !spi.mosi) state_d = ST_SENDING;
            end
            ST_SENDING: begin
                if (!active) begin
                    state_d      = ST_RECEIVE;
                    cnt_in_d     = '0;
                    cnt_out_d    = '0;
                    packet_in_d  = '0;
                    packet_out_d = '0;
                    frame_err_d  = 1'b1;
                end else begin
                    packet_out_d = {1'b0, packet_out_q[OutBits-1:1]};
                    if (cnt_out_q == LastOut) begin
                        state_d   = ST_RECEIVE;
                        cnt_out_d = '0;
                    end else begin
                        cnt_out_d = cnt_out_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RECEIVE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_RECEIVE;
            cnt_in_q     <= '0;
            cnt_out_q    <= '0;
            packet_in_q  <= '0;
            packet_out_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_in_q     <= cnt_in_d;
            cnt_out_q    <= cnt_out_d;
            packet_in_q  <= packet_in_d;
            packet_out_q <= packet_out_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        spi.miso_d = 1'b0;
        case (state_q)
            ST_SEND:    spi.miso_d = 1'b1;
            ST_SENDING: spi.miso_d = packet_out_q[0];
            default:    spi.miso_d = 1'b0;
        endcase
    end

    assign spi.miso_oe  = active;
    assign o_busy       = (state_q != ST_RECEIVE);
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_param_alu_slave.sv
// Self-checking bench for param_alu_slave (DataWidth=8, selected on nss[1]):
// directed frames, aborts, reset mid-frame and random frames against a model.
module tb_param_alu_slave;
    import AluPkg::*;

    localparam int DW       = 8;
    localparam int IN_BITS  = 2 * DW + 4;
    localparam int OUT_BITS = DW + 5;
    localparam int NSS_POS  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic ferr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    Spi #(.NssWidth(2)) spi_bus ();

    param_alu_slave #(.DataWidth(DW), .NssPosition(NSS_POS)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .spi         (spi_bus),
        .o_busy      (busy),
        .o_frame_err (ferr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Only our line goes low; the neighbouring slave's line stays high.
    task automatic select(input bit on);
        spi_bus.nss = on ? 2'b01 : 2'b11;
    endtask

    // Reference: plain integer arithmetic from the operation definitions.
    function automatic logic [OUT_BITS-1:0] model(input int op, input int a, input int b);
        int r, sa, sb, s, sh;
        bit c, v, ill, n, z;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        r = 0; c = 0; v = 0; ill = 0;
        case (op)
            0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = a << sh;
            7: r = a >> sh;
            8: r = sa >>> sh;
            9: r = (sa < sb) ? 1 : 0;
            10: r = (a < b) ? 1 : 0;
            default: begin r = 0; ill = 1; end
        endcase
        r = r & 255;
        z = (r == 0);
        n = (r >= 128);
        return {ill, v, c, n, z, r[7:0]};
    endfunction

    // cut < 0: full frame. Otherwise stop after `cut` response bits, either by
    // deselecting (abort) or by asserting the asynchronous reset.
    task automatic run_frame(input int op, input int a, input int b, input int send_wait,
                             input bit desel_in_send, input int cut, input bit cut_by_reset,
                             output logic [OUT_BITS-1:0] rsp);
        logic [IN_BITS-1:0]  req;
        logic [OUT_BITS-1:0] exp;
        req = {b[7:0], a[7:0], op[3:0]};
        exp = model(op, a, b);
        rsp = '0;
        select(1'b1);
        spi_bus.mosi = 1'b1;
        @(negedge clk);
        for (int i = 0; i < IN_BITS; i++) begin
            spi_bus.mosi = req[i];
            @(negedge clk);
        end
        spi_bus.mosi = 1'b1;
        check($sformatf("operate op%0d", op), 32'({busy, spi_bus.miso_oe, spi_bus.miso_d}), 32'b110);
        @(negedge clk);
        check($sformatf("send_ready op%0d", op), 32'({busy, spi_bus.miso_oe, spi_bus.miso_d}), 32'b111);
        repeat (send_wait) @(negedge clk);
        if (desel_in_send) begin
            select(1'b0);
            repeat (2) @(negedge clk);
            check("send_deselected", 32'({busy, spi_bus.miso_oe, ferr}), 32'b100);
            select(1'b1);
        end
        spi_bus.mosi = 1'b0;
        @(negedge clk);
        for (int j = 0; j < OUT_BITS; j++) begin
            if (j == cut) begin
                if (cut_by_reset) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_mid_send", 32'({busy, spi_bus.miso_oe, spi_bus.miso_d, ferr}), 32'b0100);
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    select(1'b0);
                    @(negedge clk);
                    check("abort_send", 32'({ferr, busy, spi_bus.miso_oe}), 32'b100);
                end
                select(1'b0);
                spi_bus.mosi = 1'b0;
                @(negedge clk);
                return;
            end
            rsp[j] = spi_bus.miso_d;
            @(negedge clk);
        end
        check($sformatf("response op%0d a=%02h b=%02h", op, a[7:0], b[7:0]), 32'(rsp), 32'(exp));
        check("idle_after_frame", 32'({busy, ferr}), 32'b00);
        select(1'b0);
        spi_bus.mosi = 1'b0;
        @(negedge clk);
        $display("frame op=%0d a=%02h b=%02h rsp=%04h exp=%04h", op, a[7:0], b[7:0], rsp, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [OUT_BITS-1:0] rsp;
        select(1'b0);
        spi_bus.mosi = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'({busy, ferr, spi_bus.miso_oe}), 32'b000);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 8'h7F, 8'h01, 0, 0, -1, 0, rsp);
        check("add_7f_01_const", 32'(rsp), 32'h0A80);
        run_frame(1, 8'h10, 8'h20, 1, 0, -1, 0, rsp);
        run_frame(1, 8'h05, 8'h05, 0, 0, -1, 0, rsp);
        run_frame(6, 8'h81, 8'h03, 2, 1, -1, 0, rsp);
        run_frame(8, 8'h80, 8'h02, 0, 0, -1, 0, rsp);
        run_frame(9, 8'hFF, 8'h01, 0, 0, -1, 0, rsp);
        run_frame(10, 8'hFF, 8'h01, 0, 0, -1, 0, rsp);
        run_frame(13, 8'h12, 8'h34, 0, 0, -1, 0, rsp);
        check("illegal_const", 32'(rsp), 32'h1100);
        run_frame(0, 8'hFF, 8'h01, 0, 0, -1, 0, rsp);

        // Deselect after 7 request bits.
        select(1'b1);
        spi_bus.mosi = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            spi_bus.mosi = 1'(i & 1);
            @(negedge clk);
        end
        select(1'b0);
        @(negedge clk);
        check("abort_rx_pulse", 32'({ferr, busy, spi_bus.miso_oe}), 32'b100);
        @(negedge clk);
        check("abort_rx_single", 32'({ferr, busy}), 32'b00);
        run_frame(0, 8'h02, 8'h03, 0, 0, -1, 0, rsp);
        check("add_2_3_const", 32'(rsp), 32'h0005);

        run_frame(4, 8'hA5, 8'h3C, 0, 0, 5, 0, rsp);
        run_frame(7, 8'hF0, 8'h04, 0, 0, -1, 0, rsp);
        run_frame(3, 8'h55, 8'hAA, 1, 0, 4, 1, rsp);
        run_frame(5, 8'h0F, 8'h00, 0, 0, -1, 0, rsp);

        for (int k = 0; k < 40; k++) begin
            run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), -1, 0, rsp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
